// File: rtl/sprite_addr_gen.sv
// Sprite ROM address generator and 2-stage pixel pipeline for a VGA overlay.
// Optional macro SPRITE_TRANSPARENCY_EN: rom_data==3'b000 shows the background.
module sprite_addr_gen #(
    parameter int SPR_W  = 82,
    parameter int SPR_H  = 123,
    parameter int ADDR_W = 14,
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [2:0]        rom_data,
    input  logic [2:0]        bg_rgb,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rgb_out,
    output logic              sprite_hit,
    output logic              frame_start,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {S_IDLE, S_ABOVE, S_ROWS, S_BELOW} state_t;

    localparam logic [10:0]       H_L    = 11'(H_ACT);
    localparam logic [10:0]       V_L    = 11'(V_ACT);
    localparam logic [10:0]       W_L    = 11'(SPR_W);
    localparam logic [10:0]       H_L2   = 11'(SPR_H);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(SPR_W);

    state_t              state;
    logic [9:0]          pos_x_q;
    logic [9:0]          pos_y_q;
    logic [ADDR_W-1:0]   row_base;
    logic                hit_d1;
    logic [2:0]          bg_rgb_d1;

    // In the frame_start cycle the incoming position is already in effect,
    // so pixel (0,0) of a sprite at the origin is drawn.
    logic                fs;
    logic [9:0]          x_eff;
    logic [9:0]          y_eff;
    logic [10:0]         x_end;
    logic [10:0]         y_end;
    logic                pos_ok;
    logic                in_rect;
    logic                rows_now;
    logic                draw;
    logic                row_end;
    logic                last_row;
    logic [ADDR_W-1:0]   base_eff;
    logic [9:0]          col_off;

    assign fs          = (hcount == 10'd0) && (vcount == 10'd0);
    assign frame_start = fs & ~reset;
    assign x_eff       = fs ? pos_x : pos_x_q;
    assign y_eff       = fs ? pos_y : pos_y_q;
    assign x_end       = {1'b0, x_eff} + W_L;
    assign y_end       = {1'b0, y_eff} + H_L2;
    assign pos_ok      = ({1'b0, x_eff} < H_L) && ({1'b0, y_eff} < V_L);

    assign in_rect = (hcount >= x_eff) && ({1'b0, hcount} < x_end) &&
                     (vcount >= y_eff) && ({1'b0, vcount} < y_end) &&
                     ({1'b0, hcount} < H_L) && ({1'b0, vcount} < V_L);

    assign rows_now = fs ? (y_eff == 10'd0)
                         : ((state == S_ROWS) ||
                            ((state == S_ABOVE) && (hcount == 10'd0) && (vcount == pos_y_q)));

    assign draw     = in_rect && rows_now && pos_ok;
    assign row_end  = ({1'b0, hcount} == (H_L - 11'd1));
    assign last_row = ({1'b0, vcount} == (y_end - 11'd1)) || ({1'b0, vcount} >= (V_L - 11'd1));
    assign base_eff = fs ? '0 : row_base;
    assign col_off  = hcount - x_eff;
    assign fsm_state = state;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            row_base   <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            hit_d1     <= 1'b0;
            bg_rgb_d1  <= 3'b000;
            rgb_out    <= 3'b000;
            sprite_hit <= 1'b0;
        end else begin
            bg_rgb_d1 <= bg_rgb;
            hit_d1    <= draw;
            if (draw)
                rom_addr <= base_eff + ADDR_W'(col_off);

`ifdef SPRITE_TRANSPARENCY_EN
            if (hit_d1 && (rom_data != 3'b000)) begin
                rgb_out    <= rom_data;
                sprite_hit <= 1'b1;
            end else begin
                rgb_out    <= bg_rgb_d1;
                sprite_hit <= 1'b0;
            end
`else
            rgb_out    <= hit_d1 ? rom_data : bg_rgb_d1;
            sprite_hit <= hit_d1;
`endif

            if (fs) begin
                pos_x_q  <= pos_x;
                pos_y_q  <= pos_y;
                row_base <= '0;
                if (!pos_ok)
                    state <= S_BELOW;
                else if (pos_y == 10'd0)
                    state <= S_ROWS;
                else
                    state <= S_ABOVE;
            end else begin
                case (state)
                    S_ABOVE: begin
                        if ((hcount == 10'd0) && (vcount == pos_y_q))
                            state <= S_ROWS;
                    end
                    S_ROWS: begin
                        // Row base advances once per line, so clipped columns never shift it.
                        if ({1'b0, vcount} >= V_L) begin
                            state <= S_BELOW;
                        end else if (row_end) begin
                            row_base <= row_base + STEP;
                            if (last_row)
                                state <= S_BELOW;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Scoreboard bench for sprite_addr_gen: driver pushes expected records, a monitor checks both pipe stages.
module tb_sprite_addr_gen;

    localparam int SPR_W = 82;
    localparam int SPR_H = 123;
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    logic        vga_clk;
    logic        reset;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [2:0]  rom_data;
    logic [2:0]  bg_rgb;
    logic [13:0] rom_addr;
    logic [2:0]  rgb_out;
    logic        sprite_hit;
    logic        frame_start;
    logic [1:0]  fsm_state;

    sprite_addr_gen dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .hcount      (hcount),
        .vcount      (vcount),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .rom_data    (rom_data),
        .bg_rgb      (bg_rgb),
        .rom_addr    (rom_addr),
        .rgb_out     (rgb_out),
        .sprite_hit  (sprite_hit),
        .frame_start (frame_start),
        .fsm_state   (fsm_state)
    );

    // Asynchronous ROM model: colour is the low address bits.
    assign rom_data = rom_addr[2:0];

    // clock / reset
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // scoreboard state: record = {hit, addr[13:0], rgb[2:0]}
    logic [17:0] exp_q[$];
    logic [17:0] stage_q[$];
    int          n_checks = 0;
    int          n_errs   = 0;
    int          hit_cnt  = 0;
    logic        drv_valid = 1'b0;
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;

    int          fx = 0;
    int          fy = 0;
    bit          en = 1'b0;
    logic [13:0] last_addr = 14'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(posedge vga_clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v2 <= v1;
            v1 <= drv_valid;
        end
    end

    always @(negedge vga_clk) begin
        logic [17:0] r;
        if (v2) begin
            if (stage_q.size() == 0) begin
                check("stage2_underflow", 32'd1, 32'd0);
            end else begin
                r = stage_q.pop_front();
                check("sprite_hit", 32'(sprite_hit), 32'(r[17]));
                check("rgb_out", 32'(rgb_out), 32'(r[2:0]));
                if (sprite_hit) hit_cnt++;
            end
        end
        if (v1) begin
            if (exp_q.size() == 0) begin
                check("stage1_underflow", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(r[16:3]));
                stage_q.push_back(r);
            end
        end
    end

    // driver tasks
    task automatic drive_pixel(input int h, input int v);
        logic        hit;
        logic [2:0]  rgb;
        hcount = 10'(h);
        vcount = 10'(v);
        if (h == 0 && v == 0) begin
            fx = int'(pos_x);
            fy = int'(pos_y);
            en = 1'b1;
        end
        hit = en && (h >= fx) && (h < fx + SPR_W) && (v >= fy) && (v < fy + SPR_H) &&
              (h < H_ACT) && (v < V_ACT);
        if (hit) last_addr = 14'((v - fy) * SPR_W + (h - fx));
        rgb = hit ? last_addr[2:0] : bg_rgb;
`ifdef SPRITE_TRANSPARENCY_EN
        if (hit && last_addr[2:0] == 3'b000) begin
            hit = 1'b0;
            rgb = bg_rgb;
        end
`endif
        exp_q.push_back({hit, last_addr, rgb});
        drv_valid = 1'b1;
        @(negedge vga_clk);
        check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
        @(posedge vga_clk);
        #1;
    endtask

    // One line: column 0, two increasing column segments, then end-of-line column.
    task automatic drive_line(input int v, input int a0, input int a1, input int b0, input int b1);
        int last;
        drive_pixel(0, v);
        last = 0;
        for (int h = a0; h <= a1; h++) if (h > last) begin drive_pixel(h, v); last = h; end
        for (int h = b0; h <= b1; h++) if (h > last) begin drive_pixel(h, v); last = h; end
        if (last < H_ACT - 1) drive_pixel(H_ACT - 1, v);
    endtask

    task automatic idle();
        drv_valid = 1'b0;
        hcount = 10'd700;
        repeat (3) @(posedge vga_clk);
        #1;
    endtask

    task automatic apply_reset();
        drv_valid = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        check("queue_drained", 32'(exp_q.size() + stage_q.size()), 32'd0);
        reset = 1'b1;
        en = 1'b0;
        last_addr = 14'd0;
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_sprite_hit", 32'(sprite_hit), 32'd0);
        check("rst_rgb_out", 32'(rgb_out), 32'd0);
        check("rst_fsm_state", 32'(fsm_state), 32'd0);
        hcount = 10'd0;
        vcount = 10'd0;
        #1;
        check("rst_frame_start", 32'(frame_start), 32'd0);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
    endtask

    int base;

    initial begin
        reset  = 1'b1;
        hcount = 10'd0;
        vcount = 10'd0;
        pos_x  = 10'd0;
        pos_y  = 10'd0;
        bg_rgb = 3'b000;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("init_rom_addr", 32'(rom_addr), 32'd0);
        check("init_sprite_hit", 32'(sprite_hit), 32'd0);
        check("init_rgb_out", 32'(rgb_out), 32'd0);
        check("init_frame_start", 32'(frame_start), 32'd0);
        check("init_fsm_state", 32'(fsm_state), 32'd0);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;

        // full sprite at the origin
        pos_x = 10'd0; pos_y = 10'd0; bg_rgb = 3'b010;
        base = hit_cnt;
        for (int v = 0; v <= SPR_H; v++) drive_line(v, 0, 90, 1, 0);
        idle();
        check("origin_last_addr", 32'(rom_addr), 32'd10085);
`ifndef SPRITE_TRANSPARENCY_EN
        check("origin_hits", 32'(hit_cnt - base), 32'd10086);
`endif

        // right-edge clipping
        pos_x = 10'd600; pos_y = 10'd10; bg_rgb = 3'b011;
        base = hit_cnt;
        drive_line(0, 595, 645, 1, 0);
        for (int v = 10; v <= 133; v++) drive_line(v, 595, 645, 1, 0);
        idle();
`ifndef SPRITE_TRANSPARENCY_EN
        check("clip_x_hits", 32'(hit_cnt - base), 32'd4920);
`endif

        // mid-frame position change applies only from the next frame
        pos_x = 10'd100; pos_y = 10'd40; bg_rgb = 3'b100;
        for (int f = 0; f < 2; f++) begin
            drive_line(0, 95, 110, 178, 205);
            for (int v = 40; v <= 163; v++) begin
                if (v == 50) pos_x = 10'd200;
                drive_line(v, 95, 110, 178, 205);
            end
            idle();
        end

        // reset inside the sprite, then rows continue with no drawing
        pos_x = 10'd0; pos_y = 10'd0; bg_rgb = 3'b001;
        base = hit_cnt;
        for (int v = 0; v < 60; v++) drive_line(v, 0, 20, 1, 0);
        for (int h = 0; h <= 10; h++) drive_pixel(h, 60);
        apply_reset();
        for (int h = 11; h <= 20; h++) drive_pixel(h, 60);
        drive_pixel(H_ACT - 1, 60);
        for (int v = 61; v <= 70; v++) drive_line(v, 0, 20, 1, 0);
        idle();
`ifndef SPRITE_TRANSPARENCY_EN
        check("reset_frame_hits", 32'(hit_cnt - base), 32'd1271);
`endif

        // black sprite pixels against a 101 background
        pos_x = 10'd0; pos_y = 10'd0; bg_rgb = 3'b101;
        for (int v = 0; v < 3; v++) drive_line(v, 0, 20, 1, 0);
        idle();

        // bottom clipping at V_ACT
        pos_x = 10'd0; pos_y = 10'd400; bg_rgb = 3'b110;
        base = hit_cnt;
        drive_line(0, 0, 5, 1, 0);
        for (int v = 400; v <= 485; v++) drive_line(v, 0, 5, 1, 0);
        idle();
`ifndef SPRITE_TRANSPARENCY_EN
        check("clip_y_hits", 32'(hit_cnt - base), 32'd480);
`endif

        // off-screen positions draw nothing
        base = hit_cnt;
        pos_x = 10'd640; pos_y = 10'd0; bg_rgb = 3'b111;
        for (int v = 0; v < 3; v++) drive_line(v, 630, 645, 1, 0);
        idle();
        pos_x = 10'd0; pos_y = 10'd480;
        drive_line(0, 0, 5, 1, 0);
        for (int v = 478; v <= 484; v++) drive_line(v, 0, 5, 1, 0);
        idle();
        check("offscreen_hits", 32'(hit_cnt - base), 32'd0);

        check("queues_empty", 32'(exp_q.size() + stage_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
